// File: rtl/dram_pkg.sv
// Shared types and defaults for the DRAM port arbiter.
package dram_pkg;

   localparam int unsigned N_CORES_DEF   = 4;
   localparam int unsigned ADDR_W_DEF    = 12;
   localparam int unsigned DATA_W_DEF    = 32;
   localparam int unsigned MEM_DEPTH_DEF = 51;
   localparam int unsigned GRANT_W       = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } state_t;

   // grant_id value reserved for the file requester
   localparam logic [GRANT_W-1:0] GRANT_FILE = 3'd7;

   // Successor of a core index, wrapping at n-1 back to 0
   function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] idx,
                                                  input int unsigned n);
      if (32'(idx) + 32'd1 >= n) return '0;
      return idx + GRANT_W'(1);
   endfunction

endpackage

// File: rtl/dram_arbiter_rr_picker.sv
// Combinational round-robin select: first asserted req at ptr, ptr+1, ... mod N.
module rr_picker #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 3
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] winner,
   output logic             valid
);

   localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

   // Scan from ptr with wraparound; the first hit wins
   always_comb begin
      int unsigned idx;
      winner = '0;
      valid  = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!valid && req[SEL_W'(idx)]) begin
            valid  = 1'b1;
            winner = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/dram_arbiter.sv
// Serialises core and file requests onto one single-port DRAM port.
module dram_arbiter
   import dram_pkg::*;
#(
   parameter int unsigned N_CORES   = N_CORES_DEF,
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_CORES-1:0]          core_req,
   input  logic [N_CORES-1:0]          core_we,
   input  logic [N_CORES*ADDR_W-1:0]   core_addr,
   input  logic [N_CORES*DATA_W-1:0]   core_wdata,
   output logic [N_CORES-1:0]          core_ack,
   input  logic                        file_req,
   input  logic                        file_we,
   input  logic [ADDR_W-1:0]           file_addr,
   input  logic [DATA_W-1:0]           file_wdata,
   output logic                        file_ack,
   output logic [DATA_W-1:0]           rdata,
   output logic                        err,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic                        mem_we,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic                        busy,
   output logic [GRANT_W-1:0]          grant_id
);

   state_t               state_q, state_d;
   logic [GRANT_W-1:0]   ptr_q, ptr_d;
   logic [GRANT_W-1:0]   grant_q, grant_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic                 err_q, err_d;

   logic [GRANT_W-1:0]   pick_idx;
   logic                 pick_valid;

   logic                 sel_we;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_wdata;
   logic                 in_range;

   rr_picker #(
      .N     (N_CORES),
      .IDX_W (GRANT_W)
   ) u_rr_picker (
      .req    (core_req),
      .ptr    (ptr_q),
      .winner (pick_idx),
      .valid  (pick_valid)
   );

   // Route the latched winner's live request fields
   always_comb begin
      sel_we    = file_we;
      sel_addr  = file_addr;
      sel_wdata = file_wdata;
      for (int i = 0; i < int'(N_CORES); i++) begin
         if (grant_q == GRANT_W'(i)) begin
            sel_we    = core_we[i];
            sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = core_wdata[i*DATA_W +: DATA_W];
         end
      end
      in_range = (sel_addr < ADDR_W'(MEM_DEPTH));
   end

   // Next-state, grant latch, read capture and pointer advance
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (file_req) begin
               grant_d = GRANT_FILE;
               state_d = ST_ACCESS;
            end else if (pick_valid) begin
               grant_d = pick_idx;
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            rdata_d = in_range ? mem_rdata : '0;
            err_d   = !in_range;
            state_d = ST_ACK;
         end
         ST_ACK: begin
            if (grant_q != GRANT_FILE) ptr_d = rr_next(grant_q, N_CORES);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Output decode from registered state; memory side only active in ACCESS
   always_comb begin
      mem_we    = (state_q == ST_ACCESS) && sel_we && in_range;
      mem_addr  = (state_q == ST_ACCESS) ? sel_addr  : '0;
      mem_wdata = (state_q == ST_ACCESS) ? sel_wdata : '0;
      for (int i = 0; i < int'(N_CORES); i++) begin
         core_ack[i] = (state_q == ST_ACK) && (grant_q == GRANT_W'(i));
      end
      file_ack = (state_q == ST_ACK) && (grant_q == GRANT_FILE);
      rdata    = (state_q == ST_ACK) ? rdata_q : '0;
      err      = (state_q == ST_ACK) && err_q;
      busy     = (state_q != ST_IDLE);
      grant_id = grant_q;
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter with a behavioural memory model.
module tb_dram_arbiter;

   localparam int unsigned NC = 4;
   localparam int unsigned AW = 12;
   localparam int unsigned DW = 32;

   typedef struct {
      logic [2:0]    id;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic [NC-1:0]    core_req;
   logic [NC-1:0]    core_we;
   logic [NC*AW-1:0] core_addr;
   logic [NC*DW-1:0] core_wdata;
   logic [NC-1:0]    core_ack;
   logic             file_req;
   logic             file_we;
   logic [AW-1:0]    file_addr;
   logic [DW-1:0]    file_wdata;
   logic             file_ack;
   logic [DW-1:0]    rdata;
   logic             err;
   logic [AW-1:0]    mem_addr;
   logic             mem_we;
   logic [DW-1:0]    mem_wdata;
   logic [DW-1:0]    mem_rdata;
   logic             busy;
   logic [2:0]       grant_id;

   logic [DW-1:0]    mem [0:63];
   exp_t             exp_q[$];
   int               vectors = 0;
   int               miscompares = 0;
   int               cyc = 0;
   int               we_cnt = 0;
   logic [AW-1:0]    last_waddr = '0;
   logic [DW-1:0]    last_wdata = '0;

   dram_arbiter u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .core_req   (core_req),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_ack   (core_ack),
      .file_req   (file_req),
      .file_we    (file_we),
      .file_addr  (file_addr),
      .file_wdata (file_wdata),
      .file_ack   (file_ack),
      .rdata      (rdata),
      .err        (err),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .grant_id   (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // DRAM model: combinational read, write on rising edge
   assign mem_rdata = (mem_addr < 12'd64) ? mem[mem_addr[5:0]] : '0;
   always @(posedge clk) if (mem_we && mem_addr < 12'd64) mem[mem_addr[5:0]] <= mem_wdata;

   // Record every write strobe seen by the memory
   always @(negedge clk) begin
      if (mem_we) begin
         we_cnt     <= we_cnt + 1;
         last_waddr <= mem_addr;
         last_wdata <= mem_wdata;
      end
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] ack_id(input logic [NC-1:0] ca, input logic fa);
      logic [2:0] id;
      id = 3'd6;
      if (fa && ca == '0) id = 3'd7;
      else if (!fa && $onehot(ca)) begin
         for (int i = 0; i < int'(NC); i++) if (ca[i]) id = 3'(i);
      end
      return id;
   endfunction

   // Monitor: pop one expectation per ack cycle
   always @(negedge clk) begin
      exp_t e;
      if (|core_ack || file_ack) begin
         if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'(ack_id(core_ack, file_ack)), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("ack_id",   32'(ack_id(core_ack, file_ack)), 32'(e.id));
            check("grant_id", 32'(grant_id), 32'(e.id));
            check("rdata",    rdata, e.rdata);
            check("err",      32'(err), 32'(e.err));
         end
      end
   end

   task automatic push(input logic [2:0] id, input logic [DW-1:0] rd, input logic er);
      exp_t e;
      e.id = id; e.rdata = rd; e.err = er;
      exp_q.push_back(e);
   endtask

   task automatic set_core(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      core_we[i]              = we;
      core_addr[i*AW +: AW]   = a;
      core_wdata[i*DW +: DW]  = d;
      core_req[i]             = 1'b1;
   endtask

   task automatic set_file(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      file_we = we; file_addr = a; file_wdata = d; file_req = 1'b1;
   endtask

   // Wait for n acks; optionally drop the acked request and check 3-cycle spacing
   task automatic wait_acks(input int n, input bit drop, input bit spacing);
      int          budget;
      bit          got;
      logic [NC-1:0] cm;
      logic        fm;
      int          last_cyc;
      last_cyc = -1;
      for (int k = 0; k < n; k++) begin
         budget = 0; got = 1'b0; cm = '0; fm = 1'b0;
         while (!got && budget < 100) begin
            @(negedge clk);
            budget++;
            if (|core_ack || file_ack) begin
               got = 1'b1; cm = core_ack; fm = file_ack;
               if (spacing && last_cyc >= 0) check("ack_spacing", 32'(cyc - last_cyc), 32'd3);
               last_cyc = cyc;
            end
         end
         if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: no ack after %0d cycles, expected ack %0d of %0d", budget, k + 1, n);
            return;
         end
         @(posedge clk); #1;
         if (drop) begin
            core_req = core_req & ~cm;
            if (fm) file_req = 1'b0;
         end
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_core_ack"}, 32'(core_ack), 32'd0);
      check({tag, "_file_ack"}, 32'(file_ack), 32'd0);
      check({tag, "_mem_we"},   32'(mem_we),   32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_rdata"},    rdata,         32'd0);
      check({tag, "_err"},      32'(err),      32'd0);
      check({tag, "_busy"},     32'(busy),     32'd0);
      check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
   endtask

   initial begin
      int we0;
      int budget;
      for (int i = 0; i < 64; i++) mem[i] = 32'h100 + 32'(i);
      mem[5]  = 32'h1234;
      mem[20] = 32'h55;
      rst_n = 1'b0;
      core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
      file_req = 1'b0; file_we = 1'b0; file_addr = '0; file_wdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check_quiet("reset");
      @(posedge clk); #1 rst_n = 1'b1;

      // Single read: core 2, addr 5
      @(posedge clk); #1;
      push(3'd2, 32'h1234, 1'b0);
      set_core(2, 1'b0, 12'd5, '0);
      wait_acks(1, 1'b1, 1'b0);

      // Reset during ACCESS of a core 0 write to addr 20
      set_core(0, 1'b1, 12'd20, 32'hDEAD);
      budget = 0;
      do begin @(negedge clk); budget++; end while (!mem_we && budget < 20);
      check("rst_saw_access", 32'(mem_we), 32'd1);
      #1 rst_n = 1'b0;
      #1 check_quiet("midrst");
      @(posedge clk); #1 core_req = '0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("midrst_mem20", mem[20], 32'h55);
      check("midrst_idle",  32'(busy), 32'd0);

      // After reset ptr is 0: cores 1 and 3 -> 1 first, then 3
      @(posedge clk); #1;
      push(3'd1, 32'h101, 1'b0);
      push(3'd3, 32'h103, 1'b0);
      set_core(1, 1'b0, 12'd1, '0);
      set_core(3, 1'b0, 12'd3, '0);
      wait_acks(2, 1'b1, 1'b0);

      // Single write: core 1, addr 10 (captured rdata is the old word)
      we0 = we_cnt;
      push(3'd1, 32'h10A, 1'b0);
      set_core(1, 1'b1, 12'd10, 32'hCAFE);
      wait_acks(1, 1'b1, 1'b0);
      check("wr_we_count", 32'(we_cnt - we0), 32'd1);
      check("wr_addr",     32'(last_waddr),  32'd10);
      check("wr_data",     last_wdata,       32'hCAFE);

      // File read back of addr 10
      push(3'd7, 32'hCAFE, 1'b0);
      set_file(1'b0, 12'd10, '0);
      wait_acks(1, 1'b1, 1'b0);

      // Out of range writes from core 3
      we0 = we_cnt;
      push(3'd3, 32'h0, 1'b1);
      set_core(3, 1'b1, 12'd51, 32'hBAD);
      wait_acks(1, 1'b1, 1'b0);
      push(3'd3, 32'h0, 1'b1);
      set_core(3, 1'b1, 12'hFFF, 32'hBAD);
      wait_acks(1, 1'b1, 1'b0);
      check("oor_we_count", 32'(we_cnt - we0), 32'd0);
      check("oor_mem51",    mem[51], 32'h133);

      // Core 1 read moves ptr to 2
      push(3'd1, 32'h102, 1'b0);
      set_core(1, 1'b0, 12'd2, '0);
      wait_acks(1, 1'b1, 1'b0);

      // File priority over all cores; file grant leaves ptr at 2
      push(3'd7, 32'h107, 1'b0);
      push(3'd2, 32'h112, 1'b0);
      push(3'd3, 32'h113, 1'b0);
      push(3'd0, 32'h110, 1'b0);
      push(3'd1, 32'h111, 1'b0);
      set_file(1'b0, 12'd7, '0);
      for (int i = 0; i < int'(NC); i++) set_core(i, 1'b0, 12'(16 + i), '0);
      wait_acks(5, 1'b1, 1'b0);

      // Round robin from ptr 0 with all cores holding req
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      for (int k = 0; k < 6; k++) push(3'(k % 4), 32'h128 + 32'(k % 4), 1'b0);
      for (int i = 0; i < int'(NC); i++) set_core(i, 1'b0, 12'(40 + i), '0);
      wait_acks(6, 1'b0, 1'b1);
      core_req = '0;

      repeat (5) @(negedge clk);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

endmodule
